// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter
// Round-robin arbiter that time-shares one external 2-input gate among
// NUM_REQ requesters. The winner's operands are captured on grant, driven
// onto the gate for HOLD_CYCLES cycles, then the gate output is sampled and
// returned with a one-hot done pulse. All outputs come straight from flops.
module gate_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_a,
  input  logic [NUM_REQ-1:0] op_b,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] done,
  output logic               result,
  output logic               busy,
  output logic               gate_in1,
  output logic               gate_in2,
  input  logic               gate_out,
  output logic [COUNT_W-1:0] txn_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;     // last winner; also the active requester in EVAL/DONE
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               result_q, result_d;
  logic               busy_q, busy_d;
  logic               in1_q, in1_d;
  logic               in2_q, in2_d;
  logic [COUNT_W-1:0] txn_q, txn_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  int                 idx;

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      cnt_q    <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= 1'b0;
      busy_q   <= 1'b0;
      in1_q    <= 1'b0;
      in2_q    <= 1'b0;
      txn_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      txn_q    <= txn_d;
    end
  end

  // Round-robin search starting just past the last winner, plus next-state logic.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    grant_d  = '0;
    done_d   = '0;
    result_d = result_q;
    busy_d   = busy_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    txn_d    = txn_q;
    found    = 1'b0;
    win      = '0;
    idx      = 0;

    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(ptr_q) + off) % NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found = 1'b1;
        win   = IDX_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d[win] = 1'b1;
          in1_d        = op_a[win];
          in2_d        = op_b[win];
          ptr_d        = win;
          cnt_d        = CNT_W'(HOLD_CYCLES - 1);
          busy_d       = 1'b1;
          state_d      = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          result_d       = gate_out;
          done_d[ptr_q]  = 1'b1;
          txn_d          = txn_q + 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign result    = result_q;
  assign busy      = busy_q;
  assign gate_in1  = in1_q;
  assign gate_in2  = in2_q;
  assign txn_count = txn_q;

endmodule
